// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MduXlen = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mduop_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mdu_state_t;

  typedef struct packed {
    mduop_t               mduop;
    logic [MduXlen-1:0]   opr_a;
    logic [MduXlen-1:0]   opr_b;
    logic [4:0]           rd;
  } mdu_in_t;

  function automatic logic is_div(mduop_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic is_signed_a(mduop_t op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(mduop_t op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/ex_mdu_iter_if.sv
// Request/response handshake bundle between the EX stage and the multiply/divide unit.
interface ex_mdu_iter_if
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  mduop_t          mduop;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic [4:0]      rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic [4:0]      out_rd;
  logic            busy;

  modport master (
    output in_valid, mduop, opr_a, opr_b, rd, out_ready,
    input  in_ready, out_valid, res, out_rd, busy
  );

  modport slave (
    input  in_valid, mduop, opr_a, opr_b, rd, out_ready,
    output in_ready, out_valid, res, out_rd, busy
  );

endinterface

// File: rtl/mdu_iter_step.sv
// One iteration: shift-add multiply step or restoring-divide step on a 2*XLEN register.
module mdu_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opd,
  output logic [2*XLEN-1:0] acc_nx
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opd : '0)};
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff   = rem_sh - {1'b0, opd};
    if (is_div) begin
      // Borrow means the shifted remainder is below the divisor: keep it, quotient bit 0.
      if (diff[XLEN]) acc_nx = {acc[2*XLEN-2:0], 1'b0};
      else            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_mdu_iter.sv
// Iterative RV32M multiply/divide unit; MDU_ZERO_BYPASS_EN enables the zero-operand fast path.
module ex_mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ex_mdu_iter_if.slave bus
);

  localparam int unsigned Iters = XLEN / UNROLL;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  if (UNROLL == 0 || (XLEN % UNROLL) != 0) begin : g_bad_unroll
    $error("UNROLL must divide XLEN");
  end

  mdu_state_t        state_q, state_d;
  mduop_t            op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [CntW-1:0]   cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;
  logic [XLEN-1:0]   res_q;

  logic              accept, div_in, sign_a, sign_b, neg_in, fast;
  logic [XLEN-1:0]   a_abs, b_abs, fast_res, fix_res, quo, rem;
  logic [2*XLEN-1:0] acc_fin, prod;
  logic [2*XLEN-1:0] chain [UNROLL+1];

  assign accept = (state_q == StIdle) && bus.in_valid && !flush;
  assign div_in = is_div(bus.mduop);
  assign sign_a = is_signed_a(bus.mduop) & bus.opr_a[XLEN-1];
  assign sign_b = is_signed_b(bus.mduop) & bus.opr_b[XLEN-1];
  assign a_abs  = sign_a ? ('0 - bus.opr_a) : bus.opr_a;
  assign b_abs  = sign_b ? ('0 - bus.opr_b) : bus.opr_b;
  // Remainder takes the dividend's sign; every other result takes the product/quotient sign.
  assign neg_in = (bus.mduop inside {OpRem, OpRemu}) ? sign_a : (sign_a ^ sign_b);

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (div_in) begin
      if (bus.opr_b == '0) begin
        fast     = 1'b1;
        fast_res = (bus.mduop inside {OpDiv, OpDivu}) ? '1 : bus.opr_a;
      end else if ((bus.mduop inside {OpDiv, OpRem}) && bus.opr_a == MinVal
                   && bus.opr_b == '1) begin
        fast     = 1'b1;
        fast_res = (bus.mduop == OpDiv) ? bus.opr_a : '0;
      end
`ifdef MDU_ZERO_BYPASS_EN
      else if (bus.opr_a == '0) begin
        fast = 1'b1;
      end
`endif
    end
`ifdef MDU_ZERO_BYPASS_EN
    else if (bus.opr_a == '0 || bus.opr_b == '0) begin
      fast = 1'b1;
    end
`endif
  end

  assign chain[0] = acc_q;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    mdu_iter_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div (is_div(op_q)),
      .acc    (chain[i]),
      .opd    (opd_q),
      .acc_nx (chain[i+1])
    );
  end

  always_comb begin
    acc_fin = chain[UNROLL];
    prod    = neg_q ? ('0 - acc_fin) : acc_fin;
    quo     = acc_fin[XLEN-1:0];
    rem     = acc_fin[2*XLEN-1:XLEN];
    unique case (op_q)
      OpMul:                     fix_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_res = neg_q ? ('0 - quo) : quo;
      default:                   fix_res = neg_q ? ('0 - rem) : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = fast ? StDone : StCalc;
      StCalc:  if (cnt_q == '0) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OpMul;
      rd_q  <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= bus.mduop;
      rd_q  <= bus.rd;
      neg_q <= neg_in;
      cnt_q <= CntW'(Iters - 1);
      acc_q <= {{XLEN{1'b0}}, (div_in ? a_abs : b_abs)};
      opd_q <= div_in ? b_abs : a_abs;
      if (fast) res_q <= fast_res;
    end else if (state_q == StCalc) begin
      acc_q <= chain[UNROLL];
      if (cnt_q == '0) res_q <= fix_res;
      else             cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.res       = res_q;
  assign bus.out_rd    = rd_q;

endmodule

// File: tb/tb_ex_mdu_iter.sv
// Bench for ex_mdu_iter: UNROLL=1 and UNROLL=4 instances against a latency/result model.
module tb_ex_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  mduop_t      mduop = OpMul;
  logic [31:0] opr_a = '0;
  logic [31:0] opr_b = '0;
  logic [4:0]  rd = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ex_mdu_iter_if #(.XLEN(32)) bus0 ();
  ex_mdu_iter_if #(.XLEN(32)) bus1 ();

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus0.out_ready = out_ready & ~sel;
  assign bus1.out_ready = out_ready & sel;
  assign bus0.mduop = mduop;
  assign bus1.mduop = mduop;
  assign bus0.opr_a = opr_a;
  assign bus1.opr_a = opr_a;
  assign bus0.opr_b = opr_b;
  assign bus1.opr_b = opr_b;
  assign bus0.rd = rd;
  assign bus1.rd = rd;

  ex_mdu_iter #(.XLEN(32), .UNROLL(1)) u_dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(bus0));
  ex_mdu_iter #(.XLEN(32), .UNROLL(4)) u_dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  logic        o_valid, o_in_ready, o_busy;
  logic [31:0] o_res;
  logic [4:0]  o_rd;
  assign o_valid    = sel ? bus1.out_valid : bus0.out_valid;
  assign o_in_ready = sel ? bus1.in_ready  : bus0.in_ready;
  assign o_busy     = sel ? bus1.busy      : bus0.busy;
  assign o_res      = sel ? bus1.res       : bus0.res;
  assign o_rd       = sel ? bus1.out_rd    : bus0.out_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M result rules computed with 64-bit arithmetic.
  function automatic logic [31:0] model_res(mduop_t op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      OpMul:    p = sa * sb;
      OpMulh:   p = (sa * sb) >> 32;
      OpMulhsu: p = (sa * ub) >> 32;
      OpMulhu:  p = (ua * ub) >> 32;
      OpDiv:    p = (b == 0) ? -1 : (a == 32'h8000_0000 && b == '1) ? sa : sa / sb;
      OpDivu:   p = (b == 0) ? -1 : ua / ub;
      OpRem:    p = (b == 0) ? sa : (a == 32'h8000_0000 && b == '1) ? 0 : sa % sb;
      default:  p = (b == 0) ? ua : ua % ub;
    endcase
    return 32'(p);
  endfunction

  function automatic int model_lat(logic s, mduop_t op, logic [31:0] a, logic [31:0] b);
    bit dv, fast;
    dv   = (op == OpDiv || op == OpDivu || op == OpRem || op == OpRemu);
    fast = dv && (b == 0 || ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == '1));
`ifdef MDU_ZERO_BYPASS_EN
    if (!dv && (a == 0 || b == 0)) fast = 1'b1;
    if (dv && a == 0 && b != 0) fast = 1'b1;
`endif
    return fast ? 1 : (s ? 9 : 33);
  endfunction

  // Model of the selected unit: 0 idle, 1 computing, 2 result held.
  int          m_state = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 0;
      m_res   <= '0;
      m_rd    <= '0;
    end else if (flush) begin
      m_state <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          m_rd   <= rd;
          m_pend <= model_res(mduop, opr_a, opr_b);
          if (model_lat(sel, mduop, opr_a, opr_b) == 1) begin
            m_state <= 2;
            m_res   <= model_res(mduop, opr_a, opr_b);
          end else begin
            m_state <= 1;
            m_left  <= model_lat(sel, mduop, opr_a, opr_b) - 2;
          end
        end
        1: if (m_left == 0) begin
          m_state <= 2;
          m_res   <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_in_ready", {31'b0, o_in_ready}, {31'b0, m_state == 0});
      chk("cyc_busy", {31'b0, o_busy}, {31'b0, m_state != 0});
      chk("cyc_out_valid", {31'b0, o_valid}, {31'b0, m_state == 2});
      if (m_state == 2) begin
        chk("cyc_res", o_res, m_res);
        chk("cyc_out_rd", {27'b0, o_rd}, {27'b0, m_rd});
      end
    end
  end

  task automatic chk_reset(input logic s);
    sel = s;
    #1;
    chk("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_res", o_res, 32'd0);
    chk("rst_out_rd", {27'b0, o_rd}, 32'd0);
  endtask

  task automatic run_op(input logic s, input mduop_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input int hold,
                        input logic [31:0] exp_res, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    sel = s; mduop = op; opr_a = a; opr_b = b; rd = r; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, o_res, exp_res);
    chk({name, "_rd"}, {27'b0, o_rd}, {27'b0, r});
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_res"}, o_res, exp_res);
      chk({name, "_hold_rd"}, {27'b0, o_rd}, {27'b0, r});
      chk({name, "_hold_in_ready"}, {31'b0, o_in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({name, "_back_idle"}, {31'b0, o_in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk_reset(1'b0);
    chk_reset(1'b1);

    run_op(0, OpDivu, 32'd100, 32'd7, 5'd3, 0, 32'd14, 33, "divu_100_7");
    run_op(0, OpRemu, 32'd100, 32'd7, 5'd4, 0, 32'd2, 33, "remu_100_7");
    run_op(0, OpMulh, 32'h8000_0000, 32'h8000_0000, 5'd5, 0, 32'h4000_0000, 33, "mulh_min");
    run_op(0, OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 32'hFFFF_FFFF, 33, "mulhsu_m1");
    run_op(0, OpMul, 32'hFFFF_FFF9, 32'd3, 5'd7, 0, 32'hFFFF_FFEB, 33, "mul_m7_3");
    run_op(0, OpDiv, 32'd5, 32'd0, 5'd8, 0, 32'hFFFF_FFFF, 1, "div_by0");
    run_op(0, OpRem, 32'd5, 32'd0, 5'd9, 0, 32'd5, 1, "rem_by0");
    run_op(0, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 32'h8000_0000, 1, "div_ovf");
    run_op(0, OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 32'd0, 1, "rem_ovf");
    run_op(0, OpDivu, 32'd1000, 32'd10, 5'd12, 10, 32'd100, 33, "backpressure");

    // Flush in the fifth compute cycle, with a competing request the same cycle.
    @(negedge clk);
    sel = 1'b0; mduop = OpDiv; opr_a = 32'd100; opr_b = 32'd7; rd = 5'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; mduop = OpMul; opr_a = 32'd3; opr_b = 32'd4;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", {31'b0, o_in_ready}, 32'd1);
    repeat (40) begin
      @(posedge clk);
      #1 chk("flush_quiet", {31'b0, o_valid}, 32'd0);
    end
    run_op(0, OpDiv, 32'd9, 32'd3, 5'd14, 0, 32'd3, 33, "div_9_3");

    run_op(1, OpRem, 32'hFFFF_FFF7, 32'd2, 5'd15, 0, 32'hFFFF_FFFF, 9, "u4_rem_m9_2");
`ifdef MDU_ZERO_BYPASS_EN
    run_op(1, OpMul, 32'd0, 32'd5, 5'd16, 0, 32'd0, 1, "u4_mul_0_5");
`else
    run_op(1, OpMul, 32'd0, 32'd5, 5'd16, 0, 32'd0, 9, "u4_mul_0_5");
`endif

    // Reset in the middle of a computation.
    @(negedge clk);
    sel = 1'b1; mduop = OpMul; opr_a = 32'd12; opr_b = 32'd12; rd = 5'd17; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_reset(1'b1);

    for (int i = 0; i < 150; i++) begin
      logic        s;
      mduop_t      op;
      logic [31:0] a, b;
      s  = 1'($urandom_range(0, 1));
      op = mduop_t'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(s, op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
             model_res(op, a, b), model_lat(s, op, a, b), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule
